mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (IF) and the MEM-stage data access of ToruMIPS.
//  Grants one requester at a time, drives the bus, waits for bus_ack, returns read data plus a one-cycle ack.
//  Asserts per-requester stall to the pipeline while a request is pending. Aborts hung accesses after a timeout.
// PARAMETERS
//  ADDR_W   32  address width, both requesters and bus
//  DATA_W   32  data width; byte selects are DATA_W/8 wide
//  TIMEOUT  15  BUSY cycles without bus_ack before abort (>=2)
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst        in   1          reset, synchronous, active-high
//  if_req     in   1          IF read request, level, held until if_ack
//  if_addr    in   ADDR_W     IF read address
//  if_rdata   out  DATA_W     IF read data, valid with if_ack, held until next if_ack
//  if_ack     out  1          one-cycle IF completion pulse
//  mem_req    in   1          MEM request, level, held until mem_ack
//  mem_we     in   1          1 = store, 0 = load
//  mem_sel    in   DATA_W/8   byte enables
//  mem_addr   in   ADDR_W     MEM address
//  mem_wdata  in   DATA_W     store data
//  mem_rdata  out  DATA_W     load data, valid with mem_ack, held until next mem_ack
//  mem_ack    out  1          one-cycle MEM completion pulse
//  bus_ce     out  1          bus cycle active
//  bus_we     out  1          bus write enable
//  bus_sel    out  DATA_W/8   bus byte enables (all ones for IF)
//  bus_addr   out  ADDR_W     bus address
//  bus_wdata  out  DATA_W     bus write data (zero for IF)
//  bus_rdata  in   DATA_W     bus read data, sampled when bus_ack=1
//  bus_ack    in   1          bus completion, one cycle
//  stall_if   out  1          if_req & ~if_ack (combinational)
//  stall_mem  out  1          mem_req & ~mem_ack (combinational)
//  bus_err    out  1          one-cycle timeout pulse, concurrent with the aborted ack
// BEHAVIOUR
//  - Reset: state IDLE, all registered outputs 0 (bus_*, *_ack, *_rdata, bus_err), timeout counter 0, last_grant=IF.
//  - Reset mid-transaction: transaction abandoned, bus_ce=0 after that edge, no ack issued.
//  - FSM: IDLE, BUSY_IF, BUSY_MEM.
//  - IDLE: a requester is eligible if its req=1 and its ack is not asserted this cycle (no duplicate grant).
//    Both eligible: MEM wins (default). Grant at edge: latch addr/we/sel/wdata into bus_* regs, bus_ce=1, counter=0.
//  - BUSY_x: bus_* held stable. On bus_ack=1: latch bus_rdata into x_rdata, x_ack=1 next cycle, bus_ce=0, go IDLE.
//  - Latency: grant edge -> bus_ce; bus_ack at cycle N -> x_ack at N+1. Min req-to-ack = 3 cycles (ack in 1st BUSY cycle).
//  - Back-to-back: IDLE lasts exactly one cycle between transactions when another requester is eligible.
//  - Timeout: counter increments each BUSY cycle with bus_ack=0; at TIMEOUT-1 and bus_ack=0: bus_ce=0,
//    x_ack=1 with x_rdata=0, bus_err=1 (one cycle), go IDLE. bus_ack on that same cycle wins: normal completion, no err.
//  - Store: x_rdata for MEM unchanged-to-bus_rdata rule still applies (latched; content don't-care for stores).
//  - bus_ack in IDLE ignored. Requester changes of addr/data during BUSY ignored (latched at grant).
// CONFIGURATION
//  ROUND_ROBIN_EN defined: last_grant reg updated at every grant; on conflict in IDLE grant the requester
//    not granted last. Reset last_grant=IF, so first conflict grants MEM.
//  ROUND_ROBIN_EN undefined: fixed priority MEM > IF; no last_grant reg.
// TESTING
//  1 IF read only, if_addr=0x0000_0040, bus_ack 2 cycles after bus_ce, bus_rdata=0x3401_1100 ->
//    bus_sel=4'hF, bus_we=0; if_ack one cycle, if_rdata=0x3401_1100; stall_if=1 until ack cycle.
//  2 if_req and mem_req (store, addr 0x100, sel 4'b0011, wdata 0xDEAD_BEEF) same cycle -> MEM granted first,
//    bus_we=1, bus_sel=4'b0011; mem_ack; one IDLE cycle; then IF granted; stall_if high throughout.
//  3 ROUND_ROBIN_EN, three successive conflicts -> grant order MEM, IF, MEM; without macro MEM, MEM, MEM.
//  4 MEM load, bus_ack never -> after 15 BUSY cycles bus_ce=0, mem_ack=1, mem_rdata=0, bus_err=1 one cycle.
//  5 bus_ack asserted exactly on 15th BUSY cycle, bus_rdata=0x1234_5678 -> mem_ack, mem_rdata=0x1234_5678, bus_err=0.
//  6 rst pulsed during BUSY_IF -> next cycle bus_ce=0, if_ack=0, if_rdata=0; after release held if_req is re-granted.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-port memory bus between instruction fetch and MEM-stage data access.
// Define ROUND_ROBIN_EN to alternate grants on conflict; otherwise MEM has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic                bus_ce,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bus_ce_q, bus_ce_d;
  logic              bus_we_q, bus_we_d;
  logic [SelW-1:0]   bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              bus_err_q, bus_err_d;

  // A requester whose ack is showing this cycle is still holding req; don't re-grant it.
  logic if_elig, mem_elig, grant_mem, grant_if;
  assign if_elig  = if_req & ~if_ack_q;
  assign mem_elig = mem_req & ~mem_ack_q;

`ifdef ROUND_ROBIN_EN
  // 0 = IF granted last, 1 = MEM granted last.
  logic last_grant_q, last_grant_d;
  assign grant_mem = mem_elig & (~if_elig | ~last_grant_q);
  assign last_grant_d = (state_q == StIdle && (grant_mem || grant_if)) ? grant_mem : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign grant_mem = mem_elig;
`endif
  assign grant_if = if_elig & ~grant_mem;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d     = StBusyMem;
          cnt_d       = '0;
          bus_ce_d    = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (grant_if) begin
          state_d     = StBusyIf;
          cnt_d       = '0;
          bus_ce_d    = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = '1;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
        end
      end
      StBusyIf, StBusyMem: begin
        // A bus_ack arriving on the last allowed cycle still completes normally.
        if (bus_ack || cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          bus_ce_d  = 1'b0;
          bus_err_d = ~bus_ack;
          if (state_q == StBusyIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ack ? bus_rdata : '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus_ack ? bus_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        bus_ce_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_ce    = bus_ce_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: a transaction-level model predicts grants, bus
// contents and completions; a scoreboard matches each ack against the predicted response.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned SEL_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [SEL_W-1:0]  mem_sel = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              bus_ce, bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              bus_ack = 1'b0;
  logic              stall_if, stall_mem, bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
    bit          err;
  } resp_t;
  resp_t sb_q[$];

  // Model state: owner 0 = bus free, 1 = IF transaction, 2 = MEM transaction.
  int          m_owner = 0;
  int unsigned m_wait = 0;
  bit          m_valid = 0;
  bit          m_last_mem = 0;
  bit          e_if_ack = 0, e_mem_ack = 0, e_err = 0, e_we = 0;
  logic [31:0] e_if_rdata = '0, e_mem_rdata = '0, e_addr = '0, e_wdata = '0;
  logic [3:0]  e_sel = '0;
  bit          n_if_ack, n_mem_ack, n_err, el_if, el_mem, pick_mem;
  logic [31:0] done_data;

  // Reference model, evaluated mid-cycle: check this cycle, then predict the next.
  always @(negedge clk) begin
    if (m_valid) begin
      check("bus_ce", bus_ce, m_owner != 0);
      check("if_ack", if_ack, e_if_ack);
      check("mem_ack", mem_ack, e_mem_ack);
      check("bus_err", bus_err, e_err);
      check("if_rdata", if_rdata, e_if_rdata);
      check("mem_rdata", mem_rdata, e_mem_rdata);
      check("stall_if", stall_if, if_req & ~e_if_ack);
      check("stall_mem", stall_mem, mem_req & ~e_mem_ack);
      if (m_owner != 0) begin
        check("bus_we", bus_we, e_we);
        check("bus_sel", bus_sel, e_sel);
        check("bus_addr", bus_addr, e_addr);
        check("bus_wdata", bus_wdata, e_wdata);
      end
    end
    if (rst) begin
      m_valid = 1; m_owner = 0; m_wait = 0; m_last_mem = 0;
      e_if_ack = 0; e_mem_ack = 0; e_err = 0;
      e_if_rdata = '0; e_mem_rdata = '0;
    end else if (m_valid) begin
      n_if_ack = 0; n_mem_ack = 0; n_err = 0;
      if (m_owner != 0) begin
        if (bus_ack || m_wait == TIMEOUT - 1) begin
          done_data = bus_ack ? bus_rdata : 32'h0;
          n_err = !bus_ack;
          if (m_owner == 1) begin n_if_ack = 1; e_if_rdata = done_data; end
          else begin n_mem_ack = 1; e_mem_rdata = done_data; end
          sb_q.push_back('{is_mem: (m_owner == 2), rdata: done_data, err: n_err});
          m_owner = 0;
        end else begin
          m_wait++;
        end
      end else begin
        el_if  = if_req && !e_if_ack;
        el_mem = mem_req && !e_mem_ack;
`ifdef ROUND_ROBIN_EN
        pick_mem = (el_if && el_mem) ? !m_last_mem : el_mem;
`else
        pick_mem = el_mem;
`endif
        if (el_if || el_mem) begin
          m_owner = pick_mem ? 2 : 1;
          m_last_mem = pick_mem;
          m_wait = 0;
          e_we    = pick_mem ? mem_we : 1'b0;
          e_sel   = pick_mem ? mem_sel : 4'hF;
          e_addr  = pick_mem ? mem_addr : if_addr;
          e_wdata = pick_mem ? mem_wdata : 32'h0;
        end
      end
      e_if_ack = n_if_ack; e_mem_ack = n_mem_ack; e_err = n_err;
    end
  end

  // Scoreboard monitor: every ack must match the oldest predicted completion.
  int unsigned n_if_seen = 0, n_mem_seen = 0, n_err_seen = 0;
  resp_t r;
  always @(negedge clk) begin
    if (m_valid && (if_ack === 1'b1 || mem_ack === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {if_ack, mem_ack}, 2'b00);
      end else begin
        r = sb_q.pop_front();
        check("sb_who", {if_ack, mem_ack}, r.is_mem ? 2'b01 : 2'b10);
        check("sb_rdata", r.is_mem ? mem_rdata : if_rdata, r.rdata);
        check("sb_err", bus_err, r.err);
        if (r.is_mem) n_mem_seen++; else n_if_seen++;
        if (r.err) n_err_seen++;
      end
    end
  end

  // IF requester: holds req until ack, occasionally wiggling the address while waiting.
  initial begin
    @(posedge clk); #1;
    forever begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if_req = 1'b1; if_addr = $urandom;
      forever begin
        @(negedge clk);
        if (if_ack === 1'b1) break;
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      end
      @(posedge clk); #1;
      if_req = 1'b0;
    end
  end

  // MEM requester: random loads and stores.
  initial begin
    @(posedge clk); #1;
    forever begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      mem_req = 1'b1; mem_we = 1'($urandom); mem_sel = 4'($urandom_range(1, 15));
      mem_addr = $urandom; mem_wdata = $urandom;
      forever begin
        @(negedge clk);
        if (mem_ack === 1'b1) break;
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) begin mem_addr = $urandom; mem_wdata = $urandom; end
      end
      @(posedge clk); #1;
      mem_req = 1'b0;
    end
  end

  // Bus slave: short latencies, the last-cycle boundary, and no response at all.
  int unsigned s_cnt = 0, s_lat = 0, s_pick;
  initial begin
    forever begin
      @(posedge clk); #1;
      bus_rdata = $urandom;
      if (bus_ce === 1'b1) begin
        if (s_cnt == 0) begin
          s_pick = $urandom_range(0, 19);
          if (s_pick < 14)       s_lat = s_pick % 4;
          else if (s_pick < 16)  s_lat = (s_pick == 14) ? TIMEOUT - 2 : TIMEOUT - 1;
          else                   s_lat = 1000;
        end
        bus_ack = (s_cnt == s_lat);
        s_cnt++;
      end else begin
        s_cnt = 0;
        bus_ack = ($urandom_range(0, 9) == 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (1200) @(posedge clk);
      // Hit reset while an IF transaction is on the bus.
      begin
        int unsigned tries;
        tries = 0;
        while (m_owner != 1 && tries < 400) begin
          @(negedge clk);
          tries++;
        end
        if (m_owner != 1) check("reach_busy_if", 1'b0, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    repeat (600) @(posedge clk);
    @(negedge clk);
    check("if_acks_seen", n_if_seen > 0, 1'b1);
    check("mem_acks_seen", n_mem_seen > 0, 1'b1);
    check("timeouts_seen", n_err_seen > 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
